// File: rtl/ir_ctrl_pkg.sv
// Shared types and constants for the IR command controller.
// Contents: FSM state enum, NEC frame field bit ranges, widths, error count ceiling.
package ir_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_COMMIT = 2'd2
    } ir_state_e;

    // Field positions inside the 32-bit frame word, used as delivered (no bit reversal)
    localparam int unsigned ADDR_MSB  = 31;
    localparam int unsigned ADDR_LSB  = 24;
    localparam int unsigned NADDR_MSB = 23;
    localparam int unsigned NADDR_LSB = 16;
    localparam int unsigned CMD_MSB   = 15;
    localparam int unsigned CMD_LSB   = 8;
    localparam int unsigned NCMD_MSB  = 7;
    localparam int unsigned NCMD_LSB  = 0;

    localparam int unsigned FRAME_W   = 32;
    localparam int unsigned CMD_W     = 8;
    localparam int unsigned HOLDOFF_W = 10;

    localparam logic [7:0] ERROR_COUNT_MAX = 8'hFF;

endpackage

// File: rtl/ir_cmd_fifo.sv
// First-word fall-through command FIFO.
// Ports: clk_i/rst_ni clock and async active-low reset; push_i/data_i write side;
//        pop_i read side; full_c_o/empty_c_o status; head_c_o current head
//        (holds the last popped value while empty).
module ir_cmd_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_c_o,
    output logic             empty_c_o,
    output logic [WIDTH-1:0] head_c_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match
    assign empty_c_o = (wr_q == rd_q);
    assign full_c_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

    // A push into a full FIFO is accepted when a pop frees the slot in the same cycle
    assign do_pop  = pop_i && !empty_c_o;
    assign do_push = push_i && (!full_c_o || do_pop);

    assign head_c_o = empty_c_o ? last_q : mem_q[rd_q[AW-1:0]];

    // Pointer and last-head next state
    always_comb begin
        wr_d   = wr_q;
        rd_d   = rd_q;
        last_d = last_q;
        if (do_push) begin
            wr_d = wr_q + PW'(1);
        end
        if (do_pop) begin
            rd_d   = rd_q + PW'(1);
            last_d = mem_q[rd_q[AW-1:0]];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q   <= '0;
            rd_q   <= '0;
            last_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            last_q <= last_d;
            if (do_push) begin
                mem_q[wr_q[AW-1:0]] <= data_i;
            end
        end
    end

endmodule

// File: rtl/ir_command_controller.sv
// NEC IR frame validator, address filter, duplicate suppressor and command queue.
// Ports: clkIN/nResetIN clock and async active-low reset; frameValidIN/frameDataIN
//        frame strobe and word; cmdValidOUT/cmdReadyIN/cmdOUT command handshake;
//        overflowOUT sticky drop flag; errorCountOUT saturating complement-error count.
module ir_command_controller
    import ir_ctrl_pkg::*;
#(
    parameter int unsigned CLOCK_SPEED = 50_000,
    parameter logic [7:0]  ADDRESS     = 8'h00,
    parameter bit          ANY_ADDRESS = 1'b0,
    parameter int unsigned HOLDOFF_MS  = 150,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic               clkIN,
    input  logic               nResetIN,
    input  logic               frameValidIN,
    input  logic [FRAME_W-1:0] frameDataIN,
    output logic               cmdValidOUT,
    input  logic               cmdReadyIN,
    output logic [CMD_W-1:0]   cmdOUT,
    output logic               overflowOUT,
    output logic [7:0]         errorCountOUT
);

    localparam int unsigned          PRESC_W      = (CLOCK_SPEED > 1) ? $clog2(CLOCK_SPEED) : 1;
    localparam logic [PRESC_W-1:0]   PRESC_LAST   = PRESC_W'(CLOCK_SPEED - 1);
    localparam logic [HOLDOFF_W-1:0] HOLDOFF_LOAD = HOLDOFF_W'(HOLDOFF_MS);

    ir_state_e            state_q, state_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic                 ok_cmd_q, ok_cmd_d;
    logic                 ok_addr_q, ok_addr_d;
    logic                 match_q, match_d;
    logic                 dup_q, dup_d;
    logic [CMD_W-1:0]     last_cmd_q, last_cmd_d;
    logic [7:0]           err_q, err_d;
    logic                 ovf_q, ovf_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [HOLDOFF_W-1:0] hold_q, hold_d;

    logic [7:0]       f_addr, f_naddr, f_cmd, f_ncmd;
    logic             tick;
    logic             restart;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CMD_W-1:0] fifo_head;

    assign f_addr  = frame_q[ADDR_MSB:ADDR_LSB];
    assign f_naddr = frame_q[NADDR_MSB:NADDR_LSB];
    assign f_cmd   = frame_q[CMD_MSB:CMD_LSB];
    assign f_ncmd  = frame_q[NCMD_MSB:NCMD_LSB];

    assign tick     = (presc_q == PRESC_LAST);
    assign fifo_pop = !fifo_empty && cmdReadyIN;

    // Frame FSM, status flags and hold-off timer next state
    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        ok_cmd_d   = ok_cmd_q;
        ok_addr_d  = ok_addr_q;
        match_d    = match_q;
        dup_d      = dup_q;
        last_cmd_d = last_cmd_q;
        err_d      = err_q;
        ovf_d      = ovf_q;
        fifo_push  = 1'b0;
        restart    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (frameValidIN) begin
                    frame_d = frameDataIN;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                ok_cmd_d  = (f_cmd == ~f_ncmd);
                ok_addr_d = (f_addr == ~f_naddr);
                match_d   = ANY_ADDRESS || (f_addr == ADDRESS);
                dup_d     = (hold_q != '0) && (f_cmd == last_cmd_q);
                state_d   = ST_COMMIT;
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
                if (!ok_cmd_q || !ok_addr_q) begin
                    if (err_q != ERROR_COUNT_MAX) begin
                        err_d = err_q + 8'd1;
                    end
                end else if (match_q && dup_q) begin
                    restart = 1'b1;
                end else if (match_q) begin
                    restart    = 1'b1;
                    last_cmd_d = f_cmd;
                    if (fifo_full && !fifo_pop) begin
                        ovf_d = 1'b1;
                    end else begin
                        fifo_push = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A strobe arriving while a frame is in flight is lost
        if (frameValidIN && (state_q != ST_IDLE)) begin
            ovf_d = 1'b1;
        end

        presc_d = tick ? '0 : presc_q + PRESC_W'(1);
        hold_d  = hold_q;
        if (tick && (hold_q != '0)) begin
            hold_d = hold_q - HOLDOFF_W'(1);
        end
        // Realigning the prescaler makes the window a whole number of ms
        if (restart) begin
            presc_d = '0;
            hold_d  = HOLDOFF_LOAD;
        end
    end

    always_ff @(posedge clkIN or negedge nResetIN) begin
        if (!nResetIN) begin
            state_q    <= ST_IDLE;
            frame_q    <= '0;
            ok_cmd_q   <= 1'b0;
            ok_addr_q  <= 1'b0;
            match_q    <= 1'b0;
            dup_q      <= 1'b0;
            last_cmd_q <= '0;
            err_q      <= '0;
            ovf_q      <= 1'b0;
            presc_q    <= '0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            ok_cmd_q   <= ok_cmd_d;
            ok_addr_q  <= ok_addr_d;
            match_q    <= match_d;
            dup_q      <= dup_d;
            last_cmd_q <= last_cmd_d;
            err_q      <= err_d;
            ovf_q      <= ovf_d;
            presc_q    <= presc_d;
            hold_q     <= hold_d;
        end
    end

    ir_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clkIN),
        .rst_ni    (nResetIN),
        .push_i    (fifo_push),
        .data_i    (f_cmd),
        .pop_i     (fifo_pop),
        .full_c_o  (fifo_full),
        .empty_c_o (fifo_empty),
        .head_c_o  (fifo_head)
    );

    assign cmdValidOUT   = !fifo_empty;
    assign cmdOUT        = fifo_head;
    assign overflowOUT   = ovf_q;
    assign errorCountOUT = err_q;

endmodule
